// File: rtl/icache_axi_rd_arb_pkg.sv
// rtl/icache_axi_rd_arb_pkg.sv - shared types and AXI read constants for the I-cache read arbiter
package icache_axi_rd_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE = 2'd0;
   localparam arb_state_t ARB_ADDR = 2'd1;
   localparam arb_state_t ARB_DATA = 2'd2;

   // 4-byte beats, incrementing bursts
   localparam logic [2:0] AR_SIZE        = 3'd2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   function automatic int arb_id_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_axi_rd_arb_if.sv
// rtl/icache_axi_rd_arb_if.sv - requester-side and memory-side AXI read signals of the arbiter
interface icache_axi_rd_arb_if
   import icache_axi_rd_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32,
   parameter int LEN_BITS  = 8,
   parameter int ID_BITS   = arb_id_bits(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]                i_ar_valid;
   logic [NUM_REQ-1:0][ADDR_SIZE-1:0] i_ar_addr;
   logic [NUM_REQ-1:0][LEN_BITS-1:0]  i_ar_len;
   logic [NUM_REQ-1:0]                o_ar_ready;
   logic [NUM_REQ-1:0]                o_r_valid;
   logic [DATA_SIZE-1:0]              o_r_data;
   logic                              o_r_last;
   logic [NUM_REQ-1:0]                i_r_ready;

   logic                              o_m_ar_valid;
   logic [ADDR_SIZE-1:0]              o_m_ar_addr;
   logic [LEN_BITS-1:0]               o_m_ar_len;
   logic [ID_BITS-1:0]                o_m_ar_id;
   logic [2:0]                        o_m_ar_size;
   logic [1:0]                        o_m_ar_burst;
   logic                              i_m_ar_ready;
   logic                              i_m_r_valid;
   logic [DATA_SIZE-1:0]              i_m_r_data;
   logic                              i_m_r_last;
   logic                              o_m_r_ready;

   modport slave (
      input  i_ar_valid, i_ar_addr, i_ar_len, i_r_ready,
      input  i_m_ar_ready, i_m_r_valid, i_m_r_data, i_m_r_last,
      output o_ar_ready, o_r_valid, o_r_data, o_r_last,
      output o_m_ar_valid, o_m_ar_addr, o_m_ar_len, o_m_ar_id, o_m_ar_size, o_m_ar_burst,
      output o_m_r_ready
   );

   modport master (
      output i_ar_valid, i_ar_addr, i_ar_len, i_r_ready,
      output i_m_ar_ready, i_m_r_valid, i_m_r_data, i_m_r_last,
      input  o_ar_ready, o_r_valid, o_r_data, o_r_last,
      input  o_m_ar_valid, o_m_ar_addr, o_m_ar_len, o_m_ar_id, o_m_ar_size, o_m_ar_burst,
      input  o_m_r_ready
   );

endinterface

// File: rtl/icache_axi_rd_arb_rr_pick.sv
// rtl/icache_axi_rd_arb_rr_pick.sv - combinational round-robin selector, search starts after last_grant
module rr_pick
   import icache_axi_rd_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = arb_id_bits(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last_grant,
   output logic [N-1:0]   gnt_oh,
   output logic [IDW-1:0] gnt_idx,
   output logic           gnt_valid
);

   always_comb begin
      logic [IDW-1:0] k;
      k         = '0;
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         k = IDW'((int'(last_grant) + i) % N);
         if (!gnt_valid && req[k]) begin
            gnt_valid = 1'b1;
            gnt_oh[k] = 1'b1;
            gnt_idx   = k;
         end
      end
   end

endmodule

// File: rtl/icache_axi_rd_arb.sv
// rtl/icache_axi_rd_arb.sv - round-robin share of one AXI read port; ICACHE_ARB_LEN_CHK_EN adds a burst-length checker
module icache_axi_rd_arb
   import icache_axi_rd_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32,
   parameter int LEN_BITS  = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   icache_axi_rd_arb_if.slave  bus,
   output logic                o_busy,
   output logic                o_err
);

   localparam int ID_BITS = arb_id_bits(NUM_REQ);

   arb_state_t           state;
   logic [ID_BITS-1:0]   gnt;
   logic [ID_BITS-1:0]   last_grant;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [LEN_BITS-1:0]  len_q;

   logic [NUM_REQ-1:0]   pick_oh;
   logic [ID_BITS-1:0]   pick_idx;
   logic                 pick_valid;
   logic                 ar_hs;
   logic                 r_hs;
   logic                 r_done;

   rr_pick #(.N(NUM_REQ), .IDW(ID_BITS)) u_pick (
      .req        (bus.i_ar_valid),
      .last_grant (last_grant),
      .gnt_oh     (pick_oh),
      .gnt_idx    (pick_idx),
      .gnt_valid  (pick_valid)
   );

   assign ar_hs  = (state == ARB_ADDR) && bus.i_m_ar_ready;
   assign r_hs   = (state == ARB_DATA) && bus.i_m_r_valid && bus.o_m_r_ready;
   assign r_done = r_hs && bus.i_m_r_last;

   assign bus.o_ar_ready   = (state == ARB_IDLE) ? pick_oh : '0;
   assign bus.o_m_ar_valid = (state == ARB_ADDR);
   assign bus.o_m_ar_addr  = addr_q;
   assign bus.o_m_ar_len   = len_q;
   assign bus.o_m_ar_id    = gnt;
   assign bus.o_m_ar_size  = AR_SIZE;
   assign bus.o_m_ar_burst = AXI_BURST_INCR;
   assign bus.o_m_r_ready  = (state == ARB_DATA) && bus.i_r_ready[gnt];
   assign bus.o_r_data     = DATA_SIZE'(bus.i_m_r_data);
   assign bus.o_r_last     = bus.i_m_r_last;
   assign o_busy           = (state != ARB_IDLE);

   always_comb begin
      bus.o_r_valid = '0;
      if (state == ARB_DATA && bus.i_m_r_valid)
         bus.o_r_valid[gnt] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ARB_IDLE;
         last_grant <= ID_BITS'(NUM_REQ - 1);
         gnt        <= '0;
         addr_q     <= '0;
         len_q      <= '0;
      end else begin
         case (state)
            ARB_IDLE: if (pick_valid) begin
               gnt    <= pick_idx;
               addr_q <= bus.i_ar_addr[pick_idx];
               len_q  <= bus.i_ar_len[pick_idx];
               state  <= ARB_ADDR;
            end
            ARB_ADDR: if (ar_hs) state <= ARB_DATA;
            ARB_DATA: if (r_done) begin
               last_grant <= gnt;
               state      <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef ICACHE_ARB_LEN_CHK_EN
   logic [LEN_BITS:0] beat_cnt;
   logic              err_q;

   // a beat is wrong when its last flag disagrees with "this is beat number len_q"
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (ar_hs)
            beat_cnt <= '0;
         else if (r_hs)
            beat_cnt <= beat_cnt + 1'b1;
         if (r_hs && (bus.i_m_r_last != (beat_cnt == {1'b0, len_q})))
            err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_arb.sv
// tb/tb_icache_axi_rd_arb.sv - randomized self-checking bench for icache_axi_rd_arb
module tb_icache_axi_rd_arb;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic err;
   int   checks   = 0;
   int   failures = 0;

   bit              pend_v[NR];
   logic [AW-1:0]   pend_addr[NR];
   logic [LW-1:0]   pend_len[NR];
   int              m_last;
   bit              m_err;

   icache_axi_rd_arb_if #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_BITS(LW)) bus ();

   icache_axi_rd_arb #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_BITS(LW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus),
      .o_busy  (busy),
      .o_err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick();
      for (int i = 1; i <= NR; i++) begin
         if (pend_v[(m_last + i) % NR]) return (m_last + i) % NR;
      end
      return -1;
   endfunction

   task automatic drive_req();
      for (int i = 0; i < NR; i++) begin
         bus.i_ar_valid[i] = pend_v[i];
         bus.i_ar_addr[i]  = pend_addr[i];
         bus.i_ar_len[i]   = pend_len[i];
      end
   endtask

   task automatic add_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
      pend_v[i]    = 1'b1;
      pend_addr[i] = a;
      pend_len[i]  = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_m_ar_ready = 1'b0;
      bus.i_m_r_valid  = 1'b0;
      bus.i_m_r_data   = '0;
      bus.i_m_r_last   = 1'b0;
      bus.i_r_ready    = '0;
      for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
      drive_req();
      m_last = NR - 1;
      m_err  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},     busy, 0);
      chk({tag, "_err"},      err, 0);
      chk({tag, "_ar_ready"}, bus.o_ar_ready, 0);
      chk({tag, "_m_arv"},    bus.o_m_ar_valid, 0);
      chk({tag, "_r_valid"},  bus.o_r_valid, 0);
      chk({tag, "_m_rrdy"},   bus.o_m_r_ready, 0);
      chk({tag, "_ar_addr"},  bus.o_m_ar_addr, 0);
      chk({tag, "_ar_len"},   bus.o_m_ar_len, 0);
      chk({tag, "_ar_id"},    bus.o_m_ar_id, 0);
   endtask

   // Entered just after a clock edge with the DUT idle and at least one request pending.
   task automatic do_burst(input int stall, input int nb_ovr, input int rst_beat,
                           input bit fixed, output int obs);
      int            g;
      int            nb;
      int            b;
      int            tries;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic [DW-1:0] d;
      logic [NR-1:0] rr;
      bit            mv;
      bit            lst;
      bit            hs;

      @(negedge clk);
      g   = model_pick();
      obs = -1;
      for (int i = 0; i < NR; i++) if (bus.o_ar_ready[i]) obs = i;
      chk("idle_busy",  busy, 0);
      chk("idle_err",   err, m_err);
      chk("ar_ready",   bus.o_ar_ready, 64'(1) << g);
      chk("idle_m_arv", bus.o_m_ar_valid, 0);
      chk("idle_rvld",  bus.o_r_valid, 0);
      a = pend_addr[g];
      l = pend_len[g];
      pend_v[g] = 1'b0;
      @(posedge clk); #1;
      drive_req();

      // address phase: stray downstream R traffic must not be routed
      bus.i_m_r_valid = 1'b1;
      bus.i_r_ready   = '1;
      for (int s = 0; s <= stall; s++) begin
         bus.i_m_ar_ready = (s == stall);
         @(negedge clk);
         chk("m_ar_valid", bus.o_m_ar_valid, 1);
         chk("m_ar_addr",  bus.o_m_ar_addr, a);
         chk("m_ar_len",   bus.o_m_ar_len, l);
         chk("m_ar_id",    bus.o_m_ar_id, g);
         chk("m_ar_size",  bus.o_m_ar_size, 2);
         chk("m_ar_burst", bus.o_m_ar_burst, 1);
         chk("addr_rvld",  bus.o_r_valid, 0);
         chk("addr_mrrdy", bus.o_m_r_ready, 0);
         chk("addr_arrdy", bus.o_ar_ready, 0);
         chk("addr_busy",  busy, 1);
         @(posedge clk); #1;
      end
      bus.i_m_ar_ready = 1'b0;

      nb    = (nb_ovr >= 0) ? nb_ovr : int'(l) + 1;
      b     = 0;
      tries = 0;
      while (b < nb) begin
         if (b == rst_beat) begin
            bus.i_m_r_valid = 1'b1;
            bus.i_m_r_last  = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
            drive_req();
            m_last = NR - 1;
            m_err  = 1'b0;
            @(negedge clk);
            chk_reset_outputs("rst_mid");
            @(posedge clk); #1;
            bus.i_m_r_valid = 1'b0;
            bus.i_r_ready   = '0;
            return;
         end
         d   = fixed ? DW'(32'hA0 + b) : DW'($urandom);
         lst = (b == nb - 1);
         mv  = (tries >= 3) || ($urandom_range(0, 3) != 0);
         rr  = NR'($urandom);
         if (tries >= 3) rr[g] = 1'b1;
         bus.i_m_r_valid = mv;
         bus.i_m_r_data  = d;
         bus.i_m_r_last  = lst;
         bus.i_r_ready   = rr;
         @(negedge clk);
         chk("r_valid",   bus.o_r_valid, mv ? (64'(1) << g) : 64'(0));
         chk("m_r_ready", bus.o_m_r_ready, rr[g]);
         chk("data_busy", busy, 1);
         if (mv) begin
            chk("r_data", bus.o_r_data, d);
            chk("r_last", bus.o_r_last, lst);
         end
         hs = mv && rr[g];
`ifdef ICACHE_ARB_LEN_CHK_EN
         if (hs && (lst != (b == int'(l)))) m_err = 1'b1;
`endif
         @(posedge clk); #1;
         if (hs) begin
            b++;
            tries = 0;
         end else begin
            tries++;
         end
      end
      bus.i_m_r_valid = 1'b0;
      bus.i_m_r_last  = 1'b0;
      bus.i_r_ready   = '0;
      m_last = g;
   endtask

   int exp_rr[6] = '{0, 2, 3, 0, 2, 3};
   int obs;

   initial begin
      bus.i_ar_valid = '0;
      bus.i_ar_addr  = '0;
      bus.i_ar_len   = '0;
      for (int i = 0; i < NR; i++) begin
         pend_addr[i] = '0;
         pend_len[i]  = '0;
      end
      do_reset();
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;

      // directed single burst from requester 1
      add_req(1, 32'h0000_1000, 8'd3);
      drive_req();
      do_burst(0, -1, -1, 1'b1, obs);
      chk("t1_gnt", obs, 1);
      @(negedge clk);
      chk("t1_busy_drop", busy, 0);
      @(posedge clk); #1;

      // strict round robin among continuously requesting 0, 2, 3
      do_reset();
      add_req(0, $urandom, LW'($urandom_range(0, 3)));
      add_req(2, $urandom, LW'($urandom_range(0, 3)));
      add_req(3, $urandom, LW'($urandom_range(0, 3)));
      drive_req();
      for (int n = 0; n < 6; n++) begin
         do_burst($urandom_range(0, 2), -1, -1, 1'b0, obs);
         chk("rr_order", obs, exp_rr[n]);
         if (obs >= 0) add_req(obs, $urandom, LW'($urandom_range(0, 3)));
         drive_req();
      end

      // five-cycle AR stall
      do_burst(5, -1, -1, 1'b0, obs);

      // random mix of requests, stalls and back-pressure
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < NR; i++)
            if (!pend_v[i] && $urandom_range(0, 1) == 1)
               add_req(i, $urandom, LW'($urandom_range(0, 4)));
         if (model_pick() < 0) add_req($urandom_range(0, NR - 1), $urandom, LW'($urandom_range(0, 4)));
         drive_req();
         do_burst($urandom_range(0, 3), -1, -1, 1'b0, obs);
      end

      // early last: len 3, last on the third beat; error must stay sticky
      for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
      add_req(1, 32'h0000_2000, 8'd3);
      drive_req();
      do_burst(0, 3, -1, 1'b0, obs);
      @(negedge clk);
      chk("lenerr_idle", busy, 0);
      chk("lenerr_err",  err, m_err);
      @(posedge clk); #1;
      add_req(2, 32'h0000_3000, 8'd1);
      drive_req();
      do_burst(1, -1, -1, 1'b0, obs);
      @(negedge clk);
      chk("lenerr_sticky", err, m_err);
      @(posedge clk); #1;

      // reset during beat 1, then requester 0 must win
      add_req(2, 32'h0000_4000, 8'd3);
      drive_req();
      do_burst(0, -1, 1, 1'b0, obs);
      add_req(0, 32'h0000_5000, 8'd0);
      add_req(2, 32'h0000_6000, 8'd0);
      drive_req();
      do_burst(0, -1, -1, 1'b0, obs);
      chk("post_rst_gnt", obs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
